// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier: FSM encoding,
// default operand width and the iteration counter sizing helper.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle between the operand source and the multiplier,
// plus a debug view of the FSM state.
interface shift_add_multiplier_if
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Handshake: start is accepted on a rising edge only while the multiplier
  // is IDLE or in its DONE cycle (busy=0); a and b are captured on that same
  // edge. done pulses for one cycle when product has just been updated.
  // start seen while busy=1 is dropped, not queued.
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  state_t               dbg_state;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product,
    input  dbg_state
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product,
    output dbg_state
  );

endinterface

// File: rtl/shift_add_multiplier_adder.sv
// WIDTH-bit ripple-carry add stage: one full adder per bit, carry chained
// from bit 0 upward.
module shift_add_multiplier_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
    assign carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one conditional add of the
// multiplicand plus one right shift of {C,ACC,Q} per clock.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = count_width(WIDTH);

  state_t              state;
  state_t              state_next;
  logic                load;
  logic                step;

  logic [WIDTH-1:0]    m;
  logic [WIDTH-1:0]    q;
  logic [WIDTH-1:0]    acc;
  logic                c;
  logic [CW-1:0]       count;
  logic [2*WIDTH-1:0]  product_r;

  logic [WIDTH-1:0]    add_sum;
  logic                add_cout;
  logic [WIDTH-1:0]    pre_acc;
  logic                pre_c;
  logic [2*WIDTH:0]    shifted;
  logic                last_step;

  shift_add_multiplier_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .op_a (acc),
    .op_b (m),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // C is 0 between steps, so the no-add path is {0,ACC} as intended while
  // keeping the datapath a uniform {C,ACC,Q} register.
  always_comb begin
    pre_acc   = q[0] ? add_sum  : acc;
    pre_c     = q[0] ? add_cout : c;
    shifted   = {1'b0, pre_c, pre_acc, q[WIDTH-1:1]};
    last_step = (count == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m         <= '0;
      q         <= '0;
      acc       <= '0;
      c         <= 1'b0;
      count     <= '0;
      product_r <= '0;
    end else if (load) begin
      m     <= bus.a;
      q     <= bus.b;
      acc   <= '0;
      c     <= 1'b0;
      count <= CW'(WIDTH);
    end else if (step) begin
      c     <= shifted[2*WIDTH];
      acc   <= shifted[2*WIDTH-1:WIDTH];
      q     <= shifted[WIDTH-1:0];
      count <= count - CW'(1);
      if (last_step) begin
        product_r <= shifted[2*WIDTH-1:0];
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.product   = product_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=4): directed scenarios
// plus random operands, products checked against a queue of expected values.
module tb_shift_add_multiplier;
  import shift_add_multiplier_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  logic [2*W-1:0] exp_q[$];

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_done: product=%0h, no result expected", bus.product);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (bus.product !== e) begin
          n_err++;
          $display("FAIL sb_product: got %0h expected %0h", bus.product, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back((2*W)'(a) * (2*W)'(b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, 15));
    bus.b     = W'($urandom_range(0, 15));
  endtask

  // Ends on the negedge where done=1; counts busy cycles seen before it.
  task automatic wait_done(output int busy_cnt, output bit ok);
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 4'd5;
    bus.b     = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b product=%0h expected 0 0 00",
               bus.busy, bus.done, bus.product);
    end
    n_vec++;
    if (bus.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_run: busy=%b expected 0 at idle cycle %0d", bus.busy, i);
      end
    end
  endtask

  task automatic test_basic();
    int bc;
    bit ok;
    issue(4'd5, 4'd3);
    wait_done(bc, ok);
    n_vec++;
    if (!ok || bc != W) begin
      n_err++;
      $display("FAIL basic_latency: done_seen=%b busy_cycles=%0d expected 1 %0d", ok, bc, W);
    end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b0 || bus.product !== 8'h0F) begin
      n_err++;
      $display("FAIL basic_hold: done=%b product=%0h expected 0 0f", bus.done, bus.product);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.product !== 8'h0F) begin
      n_err++;
      $display("FAIL basic_held: product=%0h expected 0f", bus.product);
    end
  endtask

  task automatic test_carry();
    int bc;
    bit ok;
    issue(4'd15, 4'd15);
    wait_done(bc, ok);
    n_vec++;
    if (!ok || bus.product !== 8'hE1) begin
      n_err++;
      $display("FAIL carry_15x15: done_seen=%b product=%0h expected e1", ok, bus.product);
    end
    issue(4'd0, 4'd9);
    wait_done(bc, ok);
    n_vec++;
    if (!ok || bus.product !== 8'h00) begin
      n_err++;
      $display("FAIL zero_0x9: done_seen=%b product=%0h expected 00", ok, bus.product);
    end
  endtask

  task automatic test_start_while_busy();
    int bc;
    bit ok;
    issue(4'd7, 4'd6);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd2;
    bus.b     = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(bc, ok);
    n_vec++;
    if (!ok || bus.product !== 8'h2A) begin
      n_err++;
      $display("FAIL busy_ignore: done_seen=%b product=%0h expected 2a", ok, bus.product);
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_ignore_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    int late_done;
    issue(4'd9, 4'd9);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b product=%0h expected 0 0 00",
               bus.busy, bus.done, bus.product);
    end
    rst       = 1'b0;
    late_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) late_done++;
    end
    n_vec++;
    if (late_done != 0) begin
      n_err++;
      $display("FAIL reset_mid_late: active cycles=%0d expected 0", late_done);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    bit ok;
    issue(4'd3, 4'd4);
    wait_done(bc, ok);
    n_vec++;
    if (!ok || bus.product !== 8'h0C) begin
      n_err++;
      $display("FAIL b2b_first: done_seen=%b product=%0h expected 0c", ok, bus.product);
    end
    bus.start = 1'b1;
    bus.a     = 4'd11;
    bus.b     = 4'd13;
    exp_q.push_back(8'd143);
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_gap: busy=%b done=%b expected 1 0", bus.busy, bus.done);
    end
    wait_done(bc, ok);
    n_vec++;
    if (!ok || bc != W || bus.product !== 8'h8F) begin
      n_err++;
      $display("FAIL b2b_second: done_seen=%b busy_cycles=%0d product=%0h expected 1 %0d 8f",
               ok, bc, bus.product, W);
    end
  endtask

  task automatic test_random();
    int bc;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      issue(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      wait_done(bc, ok);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL random_timeout: op %0d no done within bound", i);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    test_reset();
    test_basic();
    test_carry();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();

    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d results never produced, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned multiplier built on the lab's ripple-carry add stage.
- Computes product = a × b using the shift-and-add algorithm, with one add/shift per clock and a start/busy/done handshake.
- Sits downstream of operand registers and drives its add stage each cycle: it supplies the accumulator and multiplicand as adder operands and consumes the sum and carry-out.
- Target configuration is 4×4 → 8 bits.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits; WIDTH ≥ 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled on a rising edge.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; product valid and updated.
- product  output  2*WIDTH  result register; holds its value until the next completion.

Behaviour:
- Reset is synchronous, active-high. On any edge with rst=1:
  - state=IDLE.
  - busy=0, done=0, product=0.
  - Internal registers (M, Q, ACC, carry C, count) are cleared.
  - rst has priority over start.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: M←a, Q←b, ACC←0, C←0, count←WIDTH, next state RUN.
- RUN (busy=1, done=0), every edge:
  - If Q[0]=1: {C,ACC} ← ACC + M, a (WIDTH+1)-bit result from the add stage with carry-in 0. Otherwise {C,ACC} ← {0,ACC}.
  - Then shift right by 1: {C,ACC,Q} ← {0,C,ACC,Q} >> 1. The add and shift complete in the same edge.
  - count ← count−1.
  - On the edge where count goes 1→0:
    - product ← {ACC,Q} (post-shift value).
    - Next state DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next state IDLE, or RUN if start=1 at this edge. That is a back-to-back accept, loaded exactly as in IDLE.
- Latency: start accepted at edge E0 → busy high from E0 through E0+WIDTH → done high in the cycle after edge E0+WIDTH.
  - WIDTH=4: done is seen 5 edges after the accept edge, counting the accept edge itself.
- start while busy=1 is ignored. Operands are not re-captured and the in-flight result is unaffected.
- a and b may change freely after the accept edge; only the captured M and Q are used.
- Arithmetic is unsigned. The full 2*WIDTH product never overflows: max (2^W−1)^2 < 2^(2W). The add-stage carry-out must be kept (it becomes the MSB after the shift).
- product is stable outside the completion edge. It is not cleared by starting a new multiply.
- A reset during RUN aborts the operation immediately. No done pulse is produced and product=0.
- No combinational path from inputs to outputs. busy, done and product are registered or decoded from the state register only.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - default WIDTH constant;
  - count width = clog2(WIDTH+1).
- One sub-module: the WIDTH-bit ripple-carry add stage (A, B, carry-in → sum, carry-out), instantiated once for the ACC+M add. Carry-in is tied to 0.
- The top-level contains the FSM, the M/Q/ACC/C/count registers and the product register. Estimated 150–250 lines.

Test Plan (WIDTH=4 unless noted):
- Reset: hold rst=1 for 2 edges with start=1 → busy=0, done=0, product=8'h00; no RUN entered after release until start is seen with rst=0.
- Basic multiply: a=5, b=3, start pulse → busy high 4 cycles; done pulse once; product=8'h0F and held afterwards.
- Carry-out path: a=15, b=15 → product=8'hE1 (225). Also a=0, b=9 → product=8'h00 with a done pulse.
- start while busy: a=7, b=6 accepted; 2 cycles later start=1 with a=2, b=2 → ignored; product=8'h2A (42) after the normal latency.
- Reset mid-operation: a=9, b=9 accepted; rst=1 on the 2nd RUN edge → next cycle busy=0, done=0, product=0; no late done pulse.
- Back-to-back: start=1 during the DONE cycle of 3×4 with a=11, b=13 → first product=8'h0C with a done pulse; busy re-asserts next cycle with no idle gap; second product=8'h8F (143).
